// File: rtl/if_id_ctrl_pkg.sv
// Shared definitions for the IF/ID pipeline controller: default widths,
// the decode-stage NOP and the head/skid buffer state encoding.
package if_id_ctrl_pkg;

    localparam int DEF_WORD_WIDTH = 32;
    localparam int DEF_CNT_WIDTH  = 16;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } buf_state_e;

    function automatic logic holds_beat(input buf_state_e st);
        return st != ST_EMPTY;
    endfunction

endpackage

// File: rtl/if_id_ctrl_if.sv
// IFU/IDU handshake bundle for the IF/ID controller. The master modport is the
// pipeline side driving fetch, decode-ready and hazard controls.
interface if_id_ctrl_if
    import if_id_ctrl_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) ();

    logic                  if_valid_i;
    logic [WORD_WIDTH-1:0] if_inst_i;
    logic [WORD_WIDTH-1:0] if_pc_i;
    logic                  if_ready_o;
    logic                  id_valid_o;
    logic [WORD_WIDTH-1:0] id_inst_o;
    logic [WORD_WIDTH-1:0] id_pc_o;
    logic                  id_ready_i;
    logic                  stall_i;
    logic                  flush_i;
    logic [CNT_WIDTH-1:0]  stall_cnt_o;
    logic [CNT_WIDTH-1:0]  flush_cnt_o;

    modport master (
        output if_valid_i, if_inst_i, if_pc_i, id_ready_i, stall_i, flush_i,
        input  if_ready_o, id_valid_o, id_inst_o, id_pc_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  if_valid_i, if_inst_i, if_pc_i, id_ready_i, stall_i, flush_i,
        output if_ready_o, id_valid_o, id_inst_o, id_pc_o, stall_cnt_o, flush_cnt_o
    );

endinterface

// File: rtl/if_id_ctrl_skid.sv
// Head/skid storage for the IF/ID buffer: two load-enabled instruction/PC
// registers; the head refills either from the incoming beat or from the skid.
module pipe_skid_buf #(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  head_ld_i,
    input  logic                  head_from_skid_i,
    input  logic                  skid_ld_i,
    input  logic [WORD_WIDTH-1:0] in_inst_i,
    input  logic [WORD_WIDTH-1:0] in_pc_i,
    output logic [WORD_WIDTH-1:0] head_inst_o,
    output logic [WORD_WIDTH-1:0] head_pc_o
);

    logic [WORD_WIDTH-1:0] head_inst_q;
    logic [WORD_WIDTH-1:0] head_pc_q;
    logic [WORD_WIDTH-1:0] skid_inst_q;
    logic [WORD_WIDTH-1:0] skid_pc_q;

    // Head and skid registers, each updated only under its load enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_inst_q <= {WORD_WIDTH{1'b0}};
            head_pc_q   <= {WORD_WIDTH{1'b0}};
            skid_inst_q <= {WORD_WIDTH{1'b0}};
            skid_pc_q   <= {WORD_WIDTH{1'b0}};
        end else begin
            if (head_ld_i) begin
                head_inst_q <= head_from_skid_i ? skid_inst_q : in_inst_i;
                head_pc_q   <= head_from_skid_i ? skid_pc_q   : in_pc_i;
            end
            if (skid_ld_i) begin
                skid_inst_q <= in_inst_i;
                skid_pc_q   <= in_pc_i;
            end
        end
    end

    assign head_inst_o = head_inst_q;
    assign head_pc_o   = head_pc_q;

endmodule

// File: rtl/if_id_ctrl.sv
// IF-to-ID pipeline controller: 2-entry in-order beat buffer with stall/flush
// handling and saturating stall/flush event counters.
module if_id_ctrl
    import if_id_ctrl_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    if_id_ctrl_if.slave  bus
);

    localparam logic [WORD_WIDTH-1:0] NOP_W = WORD_WIDTH'(NOP_INST);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX = {CNT_WIDTH{1'b1}};

    buf_state_e            state_q;
    logic [CNT_WIDTH-1:0]  stall_cnt_q;
    logic [CNT_WIDTH-1:0]  flush_cnt_q;

    logic                  if_ready_s;
    logic                  id_valid_s;
    logic                  enq_s;
    logic                  deq_s;
    logic                  head_ld_s;
    logic                  head_from_skid_s;
    logic                  skid_ld_s;
    logic [WORD_WIDTH-1:0] head_inst_s;
    logic [WORD_WIDTH-1:0] head_pc_s;

    // rst_n gates ready so the IFU sees 0 throughout reset and 1 right after release.
    assign if_ready_s = rst_n & (state_q != ST_FULL) & ~bus.flush_i;
    assign id_valid_s = holds_beat(state_q) & ~bus.stall_i;
    assign enq_s      = bus.if_valid_i & if_ready_s;
    assign deq_s      = id_valid_s & bus.id_ready_i & ~bus.flush_i;

    // Storage load enables derived from the current occupancy and handshakes.
    always_comb begin
        head_ld_s        = 1'b0;
        head_from_skid_s = 1'b0;
        skid_ld_s        = 1'b0;
        case (state_q)
            ST_EMPTY: head_ld_s = enq_s;
            ST_ONE: begin
                if (enq_s && !deq_s) begin
                    skid_ld_s = 1'b1;
                end else if (enq_s && deq_s) begin
                    head_ld_s = 1'b1;
                end else begin
                    head_ld_s = 1'b0;
                end
            end
            ST_FULL: begin
                head_ld_s        = deq_s;
                head_from_skid_s = 1'b1;
            end
            default: head_ld_s = 1'b0;
        endcase
    end

    // Occupancy FSM; flush overrides every other event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else if (bus.flush_i) begin
            state_q <= ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (enq_s) state_q <= ST_ONE;
                ST_ONE: begin
                    if (enq_s && !deq_s)      state_q <= ST_FULL;
                    else if (deq_s && !enq_s) state_q <= ST_EMPTY;
                end
                ST_FULL:  if (deq_s) state_q <= ST_ONE;
                default:  state_q <= ST_EMPTY;
            endcase
        end
    end

    // Saturating event counters; a flush only counts when it discards a beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= {CNT_WIDTH{1'b0}};
            flush_cnt_q <= {CNT_WIDTH{1'b0}};
        end else begin
            if (bus.stall_i && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1'b1);
            end
            if (bus.flush_i && (state_q != ST_EMPTY) && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1'b1);
            end
        end
    end

    pipe_skid_buf #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_skid (
        .clk              (clk),
        .rst_n            (rst_n),
        .head_ld_i        (head_ld_s),
        .head_from_skid_i (head_from_skid_s),
        .skid_ld_i        (skid_ld_s),
        .in_inst_i        (bus.if_inst_i),
        .in_pc_i          (bus.if_pc_i),
        .head_inst_o      (head_inst_s),
        .head_pc_o        (head_pc_s)
    );

    assign bus.if_ready_o  = if_ready_s;
    assign bus.id_valid_o  = id_valid_s;
    assign bus.id_inst_o   = id_valid_s ? head_inst_s : NOP_W;
    assign bus.id_pc_o     = id_valid_s ? head_pc_s : {WORD_WIDTH{1'b0}};
    assign bus.stall_cnt_o = stall_cnt_q;
    assign bus.flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_if_id_ctrl.sv
// Directed scoreboard bench for if_id_ctrl: streaming, backpressure, stall,
// flush, asynchronous reset and counter saturation (second 4-bit instance).
module tb_if_id_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [31:0] sb[$];

    if_id_ctrl_if #(.WORD_WIDTH(32), .CNT_WIDTH(16)) bus ();
    if_id_ctrl_if #(.WORD_WIDTH(32), .CNT_WIDTH(4))  bus4 ();

    if_id_ctrl #(.WORD_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    if_id_ctrl #(.WORD_WIDTH(32), .CNT_WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    assign bus4.if_valid_i = bus.if_valid_i;
    assign bus4.if_inst_i  = bus.if_inst_i;
    assign bus4.if_pc_i    = bus.if_pc_i;
    assign bus4.id_ready_i = bus.id_ready_i;
    assign bus4.stall_i    = bus.stall_i;
    assign bus4.flush_i    = bus.flush_i;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs after the edge, check ready and drain the scoreboard at negedge.
    task automatic drive(input logic v, input logic [31:0] pc, input logic rdy,
                         input logic stl, input logic fl, input logic exp_rdy,
                         input string tag);
        logic [31:0] head;
        @(posedge clk);
        #1;
        bus.if_valid_i = v;
        bus.if_pc_i    = pc;
        bus.if_inst_i  = inst_of(pc);
        bus.id_ready_i = rdy;
        bus.stall_i    = stl;
        bus.flush_i    = fl;
        @(negedge clk);
        chk({tag, ".if_ready"}, {31'b0, bus.if_ready_o}, {31'b0, exp_rdy});
        if (bus.id_valid_o && bus.id_ready_i) begin
            if (sb.size() == 0) begin
                chk({tag, ".spurious_beat"}, {31'b0, bus.id_valid_o}, 32'h0);
            end else begin
                head = sb.pop_front();
                chk({tag, ".id_pc"}, bus.id_pc_o, head);
                chk({tag, ".id_inst"}, bus.id_inst_o, inst_of(head));
            end
        end
        if (v && exp_rdy) sb.push_back(pc);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.if_valid_i = 1'b0;
        bus.if_pc_i    = 32'h0;
        bus.if_inst_i  = 32'h0;
        bus.id_ready_i = 1'b0;
        bus.stall_i    = 1'b0;
        bus.flush_i    = 1'b0;

        #12;
        chk("rst.if_ready",  {31'b0, bus.if_ready_o}, 32'h0);
        chk("rst.id_valid",  {31'b0, bus.id_valid_o}, 32'h0);
        chk("rst.id_inst",   bus.id_inst_o, NOP);
        chk("rst.id_pc",     bus.id_pc_o, 32'h0);
        chk("rst.stall_cnt", {16'b0, bus.stall_cnt_o}, 32'h0);
        chk("rst.flush_cnt", {16'b0, bus.flush_cnt_o}, 32'h0);
        #10;
        rst_n = 1'b1;
        #1;
        chk("rel.if_ready", {31'b0, bus.if_ready_o}, 32'h1);

        // Streaming
        drive(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, "str0");
        chk("str0.id_valid", {31'b0, bus.id_valid_o}, 32'h0);
        drive(1'b1, 32'h4, 1'b1, 1'b0, 1'b0, 1'b1, "str1");
        chk("str1.id_pc", bus.id_pc_o, 32'h0);
        drive(1'b1, 32'h8, 1'b1, 1'b0, 1'b0, 1'b1, "str2");
        chk("str2.id_pc", bus.id_pc_o, 32'h4);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, "str3");
        chk("str3.id_pc", bus.id_pc_o, 32'h8);
        chk("str.sb_empty", sb.size(), 32'h0);

        // Backpressure
        drive(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 1'b1, "bp0");
        drive(1'b1, 32'h14, 1'b0, 1'b0, 1'b0, 1'b1, "bp1");
        chk("bp1.id_pc", bus.id_pc_o, 32'h10);
        drive(1'b1, 32'h18, 1'b0, 1'b0, 1'b0, 1'b0, "bp2");
        chk("bp2.id_valid", {31'b0, bus.id_valid_o}, 32'h1);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, "bp3");
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, "bp4");
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, "bp5");
        chk("bp5.id_valid", {31'b0, bus.id_valid_o}, 32'h0);
        chk("bp.sb_empty", sb.size(), 32'h0);

        // Stall while FULL
        drive(1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 1'b1, "st_f0");
        drive(1'b1, 32'h24, 1'b0, 1'b0, 1'b0, 1'b1, "st_f1");
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, "stall");
            chk("stall.id_valid", {31'b0, bus.id_valid_o}, 32'h0);
            chk("stall.id_inst", bus.id_inst_o, NOP);
            chk("stall.id_pc", bus.id_pc_o, 32'h0);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, "st_end");
        chk("st_end.stall_cnt", {16'b0, bus.stall_cnt_o}, 32'd4);
        chk("st_end.stall_cnt4", {28'b0, bus4.stall_cnt_o}, 32'd4);
        chk("st_end.head_pc", bus.id_pc_o, 32'h20);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, "st_d0");
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, "st_d1");
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, "st_d2");
        chk("st.sb_empty", sb.size(), 32'h0);

        // Flush while FULL with a simultaneous offer
        drive(1'b1, 32'h30, 1'b0, 1'b0, 1'b0, 1'b1, "fl_f0");
        drive(1'b1, 32'h34, 1'b0, 1'b0, 1'b0, 1'b1, "fl_f1");
        drive(1'b1, 32'h38, 1'b0, 1'b0, 1'b1, 1'b0, "flush");
        sb.delete();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, "fl_a0");
        chk("fl_a0.id_valid", {31'b0, bus.id_valid_o}, 32'h0);
        chk("fl_a0.id_inst", bus.id_inst_o, NOP);
        chk("fl_a0.flush_cnt", {16'b0, bus.flush_cnt_o}, 32'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, "fl_empty");
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, "fl_a1");
        chk("fl_a1.flush_cnt", {16'b0, bus.flush_cnt_o}, 32'd1);
        chk("fl_a1.id_valid", {31'b0, bus.id_valid_o}, 32'h0);

        // Asynchronous reset while FULL
        drive(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b1, "rs_f0");
        drive(1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 1'b1, "rs_f1");
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, "rs_full");
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("arst.if_ready",  {31'b0, bus.if_ready_o}, 32'h0);
        chk("arst.id_valid",  {31'b0, bus.id_valid_o}, 32'h0);
        chk("arst.id_inst",   bus.id_inst_o, NOP);
        chk("arst.id_pc",     bus.id_pc_o, 32'h0);
        chk("arst.stall_cnt", {16'b0, bus.stall_cnt_o}, 32'h0);
        chk("arst.flush_cnt", {16'b0, bus.flush_cnt_o}, 32'h0);
        #20;
        rst_n = 1'b1;
        #1;
        chk("arel.if_ready", {31'b0, bus.if_ready_o}, 32'h1);
        chk("arel.id_valid", {31'b0, bus.id_valid_o}, 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, "arel0");
        chk("arel0.id_valid", {31'b0, bus.id_valid_o}, 32'h0);

        // Counter saturation
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, "sat");
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, "sat_end");
        chk("sat.stall_cnt4", {28'b0, bus4.stall_cnt_o}, 32'hF);
        chk("sat.stall_cnt16", {16'b0, bus.stall_cnt_o}, 32'd20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_id_ctrl.md
IF_ID_CTRL -- requirements
Module: if_id_ctrl

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 32, width of instruction and PC words.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of the performance counters.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port if_valid_i  input  1  IFU presents a fetched beat.
REQ-006 SHALL have port if_inst_i  input  WORD_WIDTH  fetched instruction.
REQ-007 SHALL have port if_pc_i  input  WORD_WIDTH  PC of the fetched instruction.
REQ-008 SHALL have port if_ready_o  output  1  controller can accept a beat this cycle.
REQ-009 SHALL have port id_valid_o  output  1  decode stage holds a valid instruction.
REQ-010 SHALL have port id_inst_o  output  WORD_WIDTH  instruction to decode; NOP when id_valid_o is low.
REQ-011 SHALL have port id_pc_o  output  WORD_WIDTH  PC to decode; 0 when id_valid_o is low.
REQ-012 SHALL have port id_ready_i  input  1  IDU consumes the head beat this cycle.
REQ-013 SHALL have port stall_i  input  1  hazard stall: hold the head beat, consume nothing.
REQ-014 SHALL have port flush_i  input  1  branch/jump redirect: discard all held beats.
REQ-015 SHALL have port stall_cnt_o  output  CNT_WIDTH  count of cycles with stall_i high.
REQ-016 SHALL have port flush_cnt_o  output  CNT_WIDTH  count of flush events that discarded at least one beat.

Function
REQ-017 SHALL hold IF-to-ID beats in a 2-entry, in-order buffer (head and skid) with states EMPTY, ONE and FULL.
REQ-018 SHALL drive if_ready_o = (state != FULL) and not flush_i, decoded from registered state only, not from id_ready_i.
REQ-019 SHALL enqueue a beat when if_valid_i and if_ready_o are both high; the beat SHALL be visible at id_* one cycle later (latency 1).
REQ-020 SHALL drive id_valid_o = (state != EMPTY) and not stall_i.
REQ-021 SHALL dequeue the head beat when id_valid_o and id_ready_i are both high; on dequeue in FULL, the skid entry SHALL become the head.
REQ-022 SHALL make the following state transitions: EMPTY to ONE on enqueue; ONE to FULL on enqueue without dequeue; ONE to EMPTY on dequeue without enqueue; ONE to ONE on simultaneous enqueue and dequeue; FULL to ONE on dequeue.
REQ-023 SHALL, while stall_i is high, perform no dequeue and leave the head contents unchanged; enqueue SHALL still be permitted if not FULL.
REQ-024 SHALL, when flush_i is high, go to EMPTY at the next edge, drop any beat offered in the same cycle, and give flush priority over enqueue, dequeue and stall.
REQ-025 SHALL drive id_inst_o to NOP 32'h0000_0013 (zero-extended to WORD_WIDTH) whenever id_valid_o is low.
REQ-026 SHALL increment stall_cnt_o each cycle stall_i is high, saturating at all-ones.
REQ-027 SHALL increment flush_cnt_o when flush_i is high and the state is not EMPTY, saturating at all-ones.
REQ-028 SHALL never reorder, duplicate or lose a beat except by flush.

Reset
REQ-029 SHALL, while rst_n is low, force state EMPTY, if_ready_o 0, id_valid_o 0, id_inst_o NOP, id_pc_o 0 and both counters 0, regardless of clk.
REQ-030 SHALL, when rst_n deasserts, assert if_ready_o in the first cycle, and a reset asserted mid-transfer SHALL discard all held beats.

Structure
REQ-031 SHALL place the NOP constant, the state encoding (EMPTY/ONE/FULL) and the default widths in the shared core package.
REQ-032 SHALL implement the head/skid storage as one sub-module, pipe_skid_buf, with load-enable registers; counters and the FSM SHALL stay in if_id_ctrl.

Verification
REQ-033 SHALL verify streaming: continuous if_valid_i with id_ready_i=1 and PCs 0x0,0x4,0x8 -> id_pc_o 0x0,0x4,0x8 on consecutive cycles, one cycle after acceptance, with if_ready_o held at 1.
REQ-034 SHALL verify backpressure: id_ready_i=0 with 3 beats offered -> 2 beats accepted, if_ready_o=0 while FULL; then id_ready_i=1 -> beats emerge in order with none lost.
REQ-035 SHALL verify stall: FULL with stall_i=1 for 4 cycles -> id_valid_o=0, id_inst_o=0x00000013, head unchanged, stall_cnt_o=4.
REQ-036 SHALL verify flush: FULL with flush_i plus a simultaneous enqueue -> next cycle EMPTY, id_valid_o=0, flush_cnt_o=1, offered beat dropped; a flush while EMPTY leaves flush_cnt_o unchanged.
REQ-037 SHALL verify reset: rst_n pulsed low asynchronously while FULL -> outputs immediately at reset values, counters 0, and if_ready_o=1 in the first cycle after release.
REQ-038 SHALL verify counter saturation: CNT_WIDTH=4 with 20 stall cycles -> stall_cnt_o=4'hF.
